// File: rtl/pneumatic_pkg.sv
// Shared types and helpers for the pneumatic step decoder/ack pair.
// No ports. Holds the FSM state enum, the step-to-actuator vector table,
// and the settle-class selector used to pick actuator travel time.
package pneumatic_pkg;

    typedef enum logic [1:0] {
        DEBOUNCE,
        SETTLE,
        DONE,
        ERR
    } state_t;

    // Highest valid step code; anything above is rejected.
    localparam logic [3:0] STEP_MAX = 4'd8;

    // Actuator drive vector, MSB first: {p1,p2,p3,v1,v2}.
    typedef struct packed {
        logic [2:0] piston;
        logic [1:0] valve;
    } act_vec_t;

    typedef enum logic [1:0] {
        SEL_MIN,
        SEL_VALVE,
        SEL_PISTON
    } settle_sel_t;

    // Handshake outputs implied by each state.
    typedef struct packed {
        logic busy;
        logic done;
        logic error;
    } status_t;

    function automatic act_vec_t step_act_vec(input logic [3:0] code);
        act_vec_t v;
        case (code)
            4'd0:    v = 5'b00000;
            4'd1:    v = 5'b11010;
            4'd2:    v = 5'b01000;
            4'd3:    v = 5'b11010;
            4'd4:    v = 5'b00010;
            4'd5:    v = 5'b00111;
            4'd6:    v = 5'b00010;
            4'd7:    v = 5'b01000;
            4'd8:    v = 5'b00101;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    // Any piston movement dominates; valve-only moves are shorter; no
    // actuator change still gets a minimum settle.
    function automatic settle_sel_t settle_sel(input act_vec_t prev_vec,
                                               input act_vec_t new_vec);
        if (prev_vec.piston != new_vec.piston)
            return SEL_PISTON;
        else if (prev_vec.valve != new_vec.valve)
            return SEL_VALVE;
        else
            return SEL_MIN;
    endfunction

    function automatic status_t state_status(input state_t s);
        status_t st;
        case (s)
            DEBOUNCE: st = 3'b100;
            SETTLE:   st = 3'b100;
            DONE:     st = 3'b010;
            ERR:      st = 3'b001;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rasp_sync.sv
// Two-flop synchroniser for the asynchronous step bus from the Pi.
// Latency: value sampled at edge e is on q after edge e+1 (first flop at e).
// Ports: clk, reset (sync, active-high), d (async bus), q (synchronised bus).
module rasp_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pneumatic_ack.sv
// Return-path handshake for the pneumatic step decoder: debounces the Pi's
// step code, times actuator settle, reports busy/done/error and step echo.
// Ports: clk, reset (sync active-high), signalrasp[3:0] (async step code),
// busy, done, error (one-hot per state class), step_ack[3:0] (accepted step).
module pneumatic_ack
    import pneumatic_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned T_PISTON_CYC  = 25_000_000,
    parameter int unsigned T_VALVE_CYC   = 10_000_000,
    parameter int unsigned T_MIN_CYC     = 1_000_000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] signalrasp,
    output logic       busy,
    output logic       done,
    output logic [3:0] step_ack,
    output logic       error
);

    // Terminal counts: the counters run from 0 to N-1 so each phase is N cycles.
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_PISTON_LAST = CNT_W'(T_PISTON_CYC - 1);
    localparam logic [CNT_W-1:0] T_VALVE_LAST  = CNT_W'(T_VALVE_CYC - 1);
    localparam logic [CNT_W-1:0] T_MIN_LAST    = CNT_W'(T_MIN_CYC - 1);

    logic [3:0]       sync_q;
    state_t           state;
    logic [3:0]       candidate;
    logic [3:0]       accepted;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] settle_last;

    rasp_sync #(.W(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (signalrasp),
        .q     (sync_q)
    );

    // Settle length for moving from the accepted step to the candidate.
    always_comb begin
        settle_last = T_MIN_LAST;
        case (settle_sel(step_act_vec(accepted), step_act_vec(candidate)))
            SEL_PISTON: settle_last = T_PISTON_LAST;
            SEL_VALVE:  settle_last = T_VALVE_LAST;
            default:    settle_last = T_MIN_LAST;
        endcase
    end

    // Outputs are registered alongside the state so they always reflect the
    // state being entered; they stay 0 during reset even though the FSM
    // starts in DEBOUNCE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DEBOUNCE;
            candidate <= '0;
            accepted  <= '0;
            count     <= '0;
            timer     <= '0;
            step_ack  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                DONE: begin
                    if (sync_q != accepted) begin
                        state                 <= DEBOUNCE;
                        candidate             <= sync_q;
                        count                 <= '0;
                        {busy, done, error}   <= state_status(DEBOUNCE);
                    end
                end

                DEBOUNCE: begin
                    {busy, done, error} <= state_status(DEBOUNCE);
                    if (sync_q != candidate) begin
                        candidate <= sync_q;
                        count     <= '0;
                    end else if (count == STABLE_LAST) begin
                        count <= '0;
                        if (candidate > STEP_MAX) begin
                            state               <= ERR;
                            {busy, done, error} <= state_status(ERR);
                        end else if (candidate == accepted) begin
                            // Bounced back to the step already in place:
                            // nothing moved, so no settle is owed.
                            state               <= DONE;
                            {busy, done, error} <= state_status(DONE);
                        end else begin
                            accepted <= candidate;
                            step_ack <= candidate;
                            timer    <= settle_last;
                            state    <= SETTLE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                SETTLE: begin
                    if (sync_q != accepted) begin
                        // Pi moved on mid-travel; restart debounce, not an error.
                        state                 <= DEBOUNCE;
                        candidate             <= sync_q;
                        count                 <= '0;
                        {busy, done, error}   <= state_status(DEBOUNCE);
                    end else if (timer == '0) begin
                        state                 <= DONE;
                        {busy, done, error}   <= state_status(DONE);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ERR: begin
                    // candidate still holds the rejected code here.
                    if (sync_q != candidate) begin
                        state                 <= DEBOUNCE;
                        candidate             <= sync_q;
                        count                 <= '0;
                        {busy, done, error}   <= state_status(DEBOUNCE);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pneumatic_ack.sv
// Scoreboard bench for pneumatic_ack: issues step codes, predicts handshake
// edges and step echo changes from the step rules, and checks them as seen.
// Ports: none (top-level bench).
module tb_pneumatic_ack;

    localparam int S  = 4;
    localparam int TP = 20;
    localparam int TV = 10;
    localparam int TM = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] signalrasp = 4'd0;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] step_ack;

    always #5 clk = ~clk;

    pneumatic_ack #(
        .STABLE_CYCLES (S),
        .T_PISTON_CYC  (TP),
        .T_VALVE_CYC   (TV),
        .T_MIN_CYC     (TM),
        .CNT_W         (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .signalrasp (signalrasp),
        .busy       (busy),
        .done       (done),
        .step_ack   (step_ack),
        .error      (error)
    );

    // Edge index: after posedge n, cyc == n.
    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    typedef enum int {EV_DONE_RISE, EV_DONE_FALL, EV_ERR_RISE, EV_ERR_FALL} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         t;
        logic [3:0] ack;
    } ev_t;
    typedef struct {
        int         t;
        logic [3:0] val;
    } ack_t;

    ev_t  ev_q[$];
    ack_t ack_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int vec_tbl [9] = '{5'b00000, 5'b11010, 5'b01000, 5'b11010, 5'b00010,
                        5'b00111, 5'b00010, 5'b01000, 5'b00101};

    function automatic int settle_time(input int a, input int c);
        if ((vec_tbl[a] >> 2) != (vec_tbl[c] >> 2)) return TP;
        if ((vec_tbl[a] & 3) != (vec_tbl[c] & 3))   return TV;
        return TM;
    endfunction

    int m_acc  = 0;   // step the Pi has had acknowledged
    int m_prev = 0;   // code currently on the bus
    int m_idle = 0;   // 0 = working, 1 = resting in done, 2 = resting in error

    // Put code c on the bus for 'hold' cycles (0 = until the outcome is seen).
    // Any change reaches the FSM 3 edges later; an outcome due at edge E
    // happens only if the next change has not reached the FSM by then.
    task automatic issue(input int c, input int hold);
        int   t, base, e, wait_n;
        bit   full;
        ev_t  ev;
        t    = cyc;
        full = (hold == 0);
        signalrasp = c[3:0];
        if (m_idle == 1) ev_q.push_back('{EV_DONE_FALL, t + 3, 4'(m_acc)});
        if (m_idle == 2) ev_q.push_back('{EV_ERR_FALL, t + 3, 4'(m_acc)});
        base = t + 3 + S;
        if (c > 8) begin
            e  = base;
            ev = '{EV_ERR_RISE, e, 4'(m_acc)};
        end else if (c == m_acc) begin
            e  = base;
            ev = '{EV_DONE_RISE, e, 4'(m_acc)};
        end else begin
            e  = base + settle_time(m_acc, c);
            ev = '{EV_DONE_RISE, e, 4'(c)};
            if (full || base <= t + hold + 2) begin
                ack_q.push_back('{base, 4'(c)});
                m_acc = c;
            end
        end
        if (full || e <= t + hold + 2) begin
            ev_q.push_back(ev);
            m_idle = (ev.kind == EV_ERR_RISE) ? 2 : 1;
        end else begin
            m_idle = 0;
        end
        m_prev = c;
        wait_n = full ? (e - t + 2) : hold;
        repeat (wait_n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        signalrasp = 4'd0;
        ev_q.delete();
        ack_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_step_ack", step_ack, 0);
        repeat (2) @(posedge clk);
        #1;
        m_acc  = 0;
        m_prev = 0;
    endtask

    // Coming out of reset the FSM is already debouncing code 0.
    task automatic release_reset();
        reset = 1'b0;
        ev_q.push_back('{EV_DONE_RISE, cyc + S, 4'd0});
        m_idle = 1;
        repeat (S + 2) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic       p_done = 1'b0;
    logic       p_err  = 1'b0;
    logic [3:0] p_ack  = 4'd0;

    task automatic take_event(input ev_kind_t kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_edge: got kind %0d, want none (cycle %0d)", kind, cyc);
        end else begin
            e = ev_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_time", cyc, e.t);
            if (kind == EV_DONE_RISE || kind == EV_ERR_RISE)
                check("ev_step_ack", step_ack, e.ack);
        end
    endtask

    always @(negedge clk) begin
        if (!(reset || rst_q)) begin
            while (ev_q.size() > 0 && ev_q[0].t < cyc) begin
                check("missing_event_time", cyc, ev_q[0].t);
                void'(ev_q.pop_front());
            end
            while (ack_q.size() > 0 && ack_q[0].t < cyc) begin
                check("missing_ack_time", cyc, ack_q[0].t);
                void'(ack_q.pop_front());
            end
            check("state_onehot", int'(busy) + int'(done) + int'(error), 1);
            if (done != p_done) take_event(done ? EV_DONE_RISE : EV_DONE_FALL);
            if (error != p_err) take_event(error ? EV_ERR_RISE : EV_ERR_FALL);
            if (step_ack != p_ack) begin
                if (ack_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got %0d, want %0d (cycle %0d)", step_ack, p_ack, cyc);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    check("ack_time", cyc, a.t);
                    check("ack_value", step_ack, a.val);
                end
            end
        end
        p_done = done;
        p_err  = error;
        p_ack  = step_ack;
    end

    // ---------------- stimulus ----------------
    initial begin
        int c, h, mode;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_error", error, 0);
        check("init_step_ack", step_ack, 0);
        @(posedge clk);
        #1;
        release_reset();

        // piston, minimum, valve-only and piston transitions
        issue(1, 0);
        issue(3, 0);
        issue(4, 0);
        issue(0, 0);
        issue(8, 0);
        issue(2, 0);
        // two-cycle glitch that returns to the accepted step
        issue(3, 2);
        issue(2, 0);
        // invalid code, then recovery
        issue(0, 0);
        issue(12, 0);
        issue(5, 0);
        // preempt a settle in progress
        issue(1, S + 3 + 8);
        issue(2, 0);

        for (int i = 0; i < 30; i++) begin
            do c = int'($urandom_range(0, 15)); while (c == m_prev);
            mode = int'($urandom_range(0, 3));
            if (mode == 0)      h = int'($urandom_range(1, 3));
            else if (mode == 1) h = int'($urandom_range(S + 3, S + 18));
            else                h = 0;
            issue(c, h);
        end

        // land in a known step, then reset in the middle of a piston settle
        issue((m_prev == 8) ? 0 : 8, 0);
        issue(1, S + 3 + 6);
        check("pre_reset_busy", busy, 1);
        apply_reset();
        release_reset();
        issue(3, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("events_left", ev_q.size(), 0);
        check("acks_left", ack_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
